burst_mem_responder: RTL and testbench

//  Memory-side responder for the cache's 128-bit burst memory interface.

---
 rtl/burst_mem_responder.sv | 134 +++++++++++++
 tb/tb_burst_mem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// Burst memory responder: services aligned 4-beat 128-bit read/write bursts from an internal RAM.
// Optional MEM_RESP_STALL_EN macro adds LFSR-driven beat/ready stalls to randomise timing.
module burst_mem_responder #(
  parameter int          DEPTH_LOG2   = 12,
  parameter int          READ_LATENCY = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_req_valid,
  output logic         mem_req_ready,
  input  logic [27:0]  mem_req_addr,
  input  logic         mem_req_rw,
  input  logic         mem_req_data_valid,
  output logic         mem_req_data_ready,
  input  logic [127:0] mem_req_data_bits,
  input  logic [15:0]  mem_req_data_mask,
  output logic         mem_resp_valid,
  output logic [127:0] mem_resp_data
);

  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_DATA} state_t;

  state_t                state, state_next;
  logic [1:0]            beat, beat_next;
  logic [3:0]            lat_cnt, lat_next;
  logic [DEPTH_LOG2-3:0] addr_q, addr_next;
  logic                  wr_en;
  logic                  stall_ok;
  logic                  issue_next;
  logic                  addr_unused;
  logic [127:0]          mem [2**DEPTH_LOG2];

  // Upper address bits alias modulo DEPTH; the low two select nothing since bursts are aligned.
  assign addr_unused = ^{mem_req_addr[27:DEPTH_LOG2], mem_req_addr[1:0]};

`ifdef MEM_RESP_STALL_EN
  logic [15:0] lfsr, lfsr_next;

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_ff @(posedge clk) begin
    if (!reset) lfsr <= LFSR_SEED;
    else        lfsr <= lfsr_next;
  end

  assign stall_ok   = lfsr[0];
  assign issue_next = lfsr_next[0];
`else
  logic [15:0] seed_unused;

  assign seed_unused = LFSR_SEED;
  assign stall_ok    = 1'b1;
  assign issue_next  = 1'b1;
`endif

  assign mem_req_ready      = (state == IDLE);
  assign mem_req_data_ready = (state == WR_DATA) && stall_ok;

  always_comb begin
    state_next = state;
    beat_next  = beat;
    lat_next   = lat_cnt;
    addr_next  = addr_q;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req_valid) begin
          addr_next = mem_req_addr[DEPTH_LOG2-1:2];
          beat_next = 2'd0;
          if (mem_req_rw) begin
            state_next = WR_DATA;
          end else begin
            lat_next   = LAT_INIT;
            state_next = (LAT_INIT == 4'd0) ? RD_BURST : RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (lat_cnt != 4'd0) lat_next = lat_cnt - 4'd1;
        // Leave one cycle early so the registered beat lands exactly READ_LATENCY after accept.
        if (lat_cnt <= 4'd1) state_next = RD_BURST;
      end
      RD_BURST: begin
        if (mem_resp_valid) begin
          beat_next = beat + 2'd1;
          if (beat == 2'd3) state_next = IDLE;
        end
      end
      WR_DATA: begin
        if (mem_req_data_valid && mem_req_data_ready) begin
          wr_en     = reset;
          beat_next = beat + 2'd1;
          if (beat == 2'd3) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state and the registered read beat
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      beat           <= 2'd0;
      lat_cnt        <= 4'd0;
      mem_resp_valid <= 1'b0;
      mem_resp_data  <= '0;
    end else begin
      state          <= state_next;
      beat           <= beat_next;
      lat_cnt        <= lat_next;
      mem_resp_valid <= (state_next == RD_BURST) && issue_next;
      if ((state_next == RD_BURST) && issue_next)
        mem_resp_data <= mem[{addr_next, beat_next}];
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_next;
  end

  // Byte-masked RAM write; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 16; i++) begin
        if (mem_req_data_mask[i]) mem[{addr_q, beat}][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: reset, read latency, write/readback, masking, back-to-back, reset mid-write.
module tb_burst_mem_responder;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [27:0]  mem_req_addr;
  logic         mem_req_rw;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0][127:0] pat_a, pat_d, pat_o, pat_n, pat_z, pat_p, exp_p, exp_r;
  logic [3:0][15:0]  m_full, m_part;

  burst_mem_responder #(.DEPTH_LOG2(12), .READ_LATENCY(L), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic req(input logic [27:0] a, input logic rw);
    int w;
    w = 0;
    mem_req_valid = 1'b1; mem_req_addr = a; mem_req_rw = rw;
    while (!mem_req_ready && w < 64) begin @(posedge clk); #1; w++; end
    n_cmp++;
    if (mem_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL req_accept: ready=%b required 1", mem_req_ready);
    end
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [27:0] a, input logic [3:0][127:0] d,
                             input logic [3:0][15:0] m, input string nm);
    int w;
    mem_req_data_valid = 1'b1; mem_req_data_bits = d[0]; mem_req_data_mask = m[0];
    req(a, 1'b1);
    for (int k = 0; k < 4; k++) begin
      mem_req_data_bits = d[k]; mem_req_data_mask = m[k];
      w = 0;
      while (!mem_req_data_ready && w < 64) begin @(posedge clk); #1; w++; end
      n_cmp++;
      if (mem_req_data_ready !== 1'b1) begin
        n_bad++; $display("FAIL %s data_ready beat%0d: got %b required 1", nm, k, mem_req_data_ready);
      end
`ifndef MEM_RESP_STALL_EN
      n_cmp++;
      if (w != 0) begin
        n_bad++; $display("FAIL %s wr_stall beat%0d: waited %0d required 0", nm, k, w);
      end
`endif
      @(posedge clk); #1;
    end
    mem_req_data_valid = 1'b0;
    n_cmp++;
    if (mem_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s wr_done_ready: got %b required 1", nm, mem_req_ready);
    end
  endtask

  task automatic read_burst(input logic [27:0] a, output logic [3:0][127:0] got, output int nb,
                            output int first, output int last, output logic rdy_after);
    int c;
    nb = 0; first = -1; last = -1; got = '0;
    req(a, 1'b0);
    c = 1;
    while (nb < 4 && c < 300) begin
      if (mem_resp_valid) begin
        got[nb] = mem_resp_data;
        if (nb == 0) first = c;
        last = c;
        nb++;
      end
      @(posedge clk); #1; c++;
    end
    rdy_after = mem_req_ready;
  endtask

  task automatic test_reset();
    mem_req_valid = 0; mem_req_addr = '0; mem_req_rw = 0;
    mem_req_data_valid = 0; mem_req_data_bits = '0; mem_req_data_mask = '0;
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    n_cmp++; if (mem_req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b required 1", mem_req_ready); end
    n_cmp++; if (mem_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b required 0", mem_resp_valid); end
    n_cmp++; if (mem_req_data_ready !== 1'b0) begin n_bad++; $display("FAIL rst_data_ready: got %b required 0", mem_req_data_ready); end
    n_cmp++; if (mem_resp_data !== 128'h0) begin n_bad++; $display("FAIL rst_resp_data: got %h required 0", mem_resp_data); end
  endtask

  task automatic test_read_latency();
    logic [3:0][127:0] got;
    int nb, first, last;
    logic rdy;
    write_burst(28'hA, pat_a, m_full, "preload");
    read_burst(28'hB, got, nb, first, last, rdy);
    n_cmp++; if (nb != 4) begin n_bad++; $display("FAIL rd_beats: got %0d required 4", nb); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (got[k] !== pat_a[k]) begin n_bad++; $display("FAIL rd_data beat%0d: got %h required %h", k, got[k], pat_a[k]); end
    end
`ifndef MEM_RESP_STALL_EN
    n_cmp++; if (first != L) begin n_bad++; $display("FAIL rd_first_beat_cycle: got %0d required %0d", first, L); end
    n_cmp++; if (last != L + 3) begin n_bad++; $display("FAIL rd_last_beat_cycle: got %0d required %0d", last, L + 3); end
`endif
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL rd_ready_after: got %b required 1", rdy); end
    n_cmp++; if (mem_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid_drop: got %b required 0", mem_resp_valid); end
    n_cmp++; if (mem_resp_data !== pat_a[3]) begin n_bad++; $display("FAIL rd_data_hold: got %h required %h", mem_resp_data, pat_a[3]); end
    // upper address bits alias onto the same line
    read_burst(28'h100_000A, got, nb, first, last, rdy);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (got[k] !== pat_a[k]) begin n_bad++; $display("FAIL alias_data beat%0d: got %h required %h", k, got[k], pat_a[k]); end
    end
  endtask

  task automatic test_write_readback();
    logic [3:0][127:0] got;
    int nb, first, last;
    logic rdy;
    write_burst(28'h4, pat_d, m_full, "wr_full");
    read_burst(28'h4, got, nb, first, last, rdy);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (got[k] !== pat_d[k]) begin n_bad++; $display("FAIL wr_readback beat%0d: got %h required %h", k, got[k], pat_d[k]); end
    end
  endtask

  task automatic test_partial_mask();
    logic [3:0][127:0] got;
    int nb, first, last;
    logic rdy;
    write_burst(28'h20, pat_z, m_full, "mask_clear");
    write_burst(28'h20, pat_p, m_part, "mask_part");
    read_burst(28'h20, got, nb, first, last, rdy);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (got[k] !== exp_p[k]) begin n_bad++; $display("FAIL mask_readback beat%0d: got %h required %h", k, got[k], exp_p[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0][127:0] got;
    int c, acc, beats, last_b, nb2;
    int acc_c [2];
    c = 0; acc = 0; beats = 0; last_b = -1; nb2 = 0; got = '0;
    acc_c[0] = -1; acc_c[1] = -1;
    mem_req_valid = 1'b1; mem_req_addr = 28'hB; mem_req_rw = 1'b0;
    while (acc < 2 && c < 300) begin
      if (mem_req_ready) begin acc_c[acc] = c; acc++; end
      if (mem_resp_valid && beats < 4) begin got[beats] = mem_resp_data; beats++; last_b = c; end
      @(posedge clk); #1; c++;
    end
    mem_req_valid = 1'b0;
    n_cmp++; if (acc != 2) begin n_bad++; $display("FAIL b2b_accepts: got %0d required 2", acc); end
    n_cmp++; if (beats != 4) begin n_bad++; $display("FAIL b2b_first_beats: got %0d required 4", beats); end
    n_cmp++; if (acc_c[1] != last_b + 1) begin n_bad++; $display("FAIL b2b_second_accept: cycle %0d required %0d", acc_c[1], last_b + 1); end
`ifndef MEM_RESP_STALL_EN
    n_cmp++; if (acc_c[1] != L + 4) begin n_bad++; $display("FAIL b2b_accept_cycle: got %0d required %0d", acc_c[1], L + 4); end
`endif
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (got[k] !== pat_a[k]) begin n_bad++; $display("FAIL b2b_data beat%0d: got %h required %h", k, got[k], pat_a[k]); end
    end
    c = 0;
    while (nb2 < 4 && c < 300) begin
      if (mem_resp_valid) nb2++;
      @(posedge clk); #1; c++;
    end
    n_cmp++; if (nb2 != 4) begin n_bad++; $display("FAIL b2b_second_beats: got %0d required 4", nb2); end
    n_cmp++; if (mem_req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle: ready=%b required 1", mem_req_ready); end
  endtask

  task automatic test_reset_mid_write();
    logic [3:0][127:0] got;
    int nb, first, last, w;
    logic rdy;
    write_burst(28'h10, pat_o, m_full, "old_line");
    mem_req_data_valid = 1'b1; mem_req_data_bits = pat_n[0]; mem_req_data_mask = 16'hFFFF;
    req(28'h10, 1'b1);
    for (int k = 0; k < 3; k++) begin
      mem_req_data_bits = pat_n[k];
      w = 0;
      while (!mem_req_data_ready && w < 64) begin @(posedge clk); #1; w++; end
      if (k < 2) begin @(posedge clk); #1; end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    mem_req_data_valid = 1'b0;
    n_cmp++; if (mem_req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b required 1", mem_req_ready); end
    n_cmp++; if (mem_req_data_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_data_ready: got %b required 0", mem_req_data_ready); end
    read_burst(28'h10, got, nb, first, last, rdy);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (got[k] !== exp_r[k]) begin n_bad++; $display("FAIL midrst_data beat%0d: got %h required %h", k, got[k], exp_r[k]); end
    end
  endtask

  initial begin
    pat_a[0] = 128'hA0A0_A0A0_0000_1111_2222_3333_4444_5550;
    pat_a[1] = 128'hA1A1_A1A1_6666_7777_8888_9999_AAAA_BBB1;
    pat_a[2] = 128'hA2A2_A2A2_CCCC_DDDD_EEEE_FFFF_0123_4562;
    pat_a[3] = 128'hA3A3_A3A3_89AB_CDEF_FEDC_BA98_7654_3213;
    pat_d[0] = 128'hD0D0_D0D0_D0D0_D0D0_1234_5678_9ABC_DEF0;
    pat_d[1] = 128'hD1D1_D1D1_D1D1_D1D1_0FED_CBA9_8765_4321;
    pat_d[2] = 128'hD2D2_D2D2_D2D2_D2D2_5555_AAAA_5555_AAAA;
    pat_d[3] = 128'hD3D3_D3D3_D3D3_D3D3_AAAA_5555_AAAA_5555;
    pat_o[0] = 128'h0101_0101_0101_0101_0101_0101_0101_0101;
    pat_o[1] = 128'h0202_0202_0202_0202_0202_0202_0202_0202;
    pat_o[2] = 128'h0303_0303_0303_0303_0303_0303_0303_0303;
    pat_o[3] = 128'h0404_0404_0404_0404_0404_0404_0404_0404;
    pat_n[0] = 128'hE0E0_E0E0_E0E0_E0E0_E0E0_E0E0_E0E0_E0E0;
    pat_n[1] = 128'hE1E1_E1E1_E1E1_E1E1_E1E1_E1E1_E1E1_E1E1;
    pat_n[2] = 128'hE2E2_E2E2_E2E2_E2E2_E2E2_E2E2_E2E2_E2E2;
    pat_n[3] = 128'hE3E3_E3E3_E3E3_E3E3_E3E3_E3E3_E3E3_E3E3;
    exp_r[0] = pat_n[0]; exp_r[1] = pat_n[1]; exp_r[2] = pat_o[2]; exp_r[3] = pat_o[3];
    pat_z = '0;
    pat_p[0] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    pat_p[1] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_DEAD_BEEF;
    pat_p[2] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    pat_p[3] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    exp_p[0] = 128'h0;
    exp_p[1] = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;
    exp_p[2] = 128'h0;
    exp_p[3] = 128'h0;
    m_full[0] = 16'hFFFF; m_full[1] = 16'hFFFF; m_full[2] = 16'hFFFF; m_full[3] = 16'hFFFF;
    m_part[0] = 16'h0000; m_part[1] = 16'h000F; m_part[2] = 16'h0000; m_part[3] = 16'h0000;

    test_reset();
    test_read_latency();
    test_write_readback();
    test_partial_mask();
    test_back_to_back();
    test_reset_mid_write();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
